// File: rtl/processor_pin_saida.sv
// Avalon-MM output PIO with atomic set/clear and a self-restoring one-shot
// pulse engine that inverts selected pins for a programmed number of clocks.
module processor_pin_saida #(
    parameter int unsigned            DATA_WIDTH  = 4,
    parameter logic [DATA_WIDTH-1:0]  RESET_VALUE = '0,
    parameter int unsigned            CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port
);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t                  state_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic [DATA_WIDTH-1:0]   pulse_mask_q;
    logic [CNT_WIDTH-1:0]    pulse_len_q;
    logic [CNT_WIDTH-1:0]    counter_q;
    logic                    overrun_q;
    logic [31:0]             readdata_q;
    logic [31:0]             readdata_d;

    logic                    wr;
    logic                    busy;
    logic [DATA_WIDTH-1:0]   wd;
    logic                    unused_wd;

    assign wr        = chipselect && !write_n;
    assign busy      = (state_q == ACTIVE);
    assign wd        = writedata[DATA_WIDTH-1:0];
    assign unused_wd = ^writedata;

    // Pins are a pure function of registers, so bus activity cannot glitch them.
    assign out_port = data_q ^ pulse_mask_q;
    assign readdata = readdata_q;

    always_comb begin
        readdata_d = '0;
        case (address)
            3'd0:    readdata_d[DATA_WIDTH-1:0] = data_q;
            3'd1:    readdata_d[DATA_WIDTH-1:0] = out_port;
            3'd2:    readdata_d[CNT_WIDTH-1:0]  = pulse_len_q;
            3'd3:    readdata_d[1:0]            = {overrun_q, busy};
            default: readdata_d                 = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            data_q       <= RESET_VALUE;
            pulse_mask_q <= '0;
            pulse_len_q  <= '0;
            counter_q    <= '0;
            overrun_q    <= 1'b0;
            readdata_q   <= '0;
        end else begin
            readdata_q <= readdata_d;

            if (wr) begin
                case (address)
                    3'd0:    data_q      <= wd;
                    3'd2:    pulse_len_q <= writedata[CNT_WIDTH-1:0];
                    3'd4:    data_q      <= data_q | wd;
                    3'd5:    data_q      <= data_q & ~wd;
                    default: ;
                endcase
            end

            case (state_q)
                IDLE: begin
                    if (wr && address == 3'd3) begin
                        if (writedata[31]) begin
                            overrun_q <= 1'b0;
                        end else if (wd != '0 && pulse_len_q != '0) begin
                            pulse_mask_q <= wd;
                            counter_q    <= pulse_len_q;
                            state_q      <= ACTIVE;
                        end
                    end
                end
                ACTIVE: begin
                    // Exit on 1 rather than 0 so inversion spans exactly pulse_len cycles.
                    counter_q <= counter_q - CNT_WIDTH'(1);
                    if (counter_q == CNT_WIDTH'(1)) begin
                        pulse_mask_q <= '0;
                        state_q      <= IDLE;
                    end
                    if (wr && address == 3'd3) begin
                        overrun_q <= !writedata[31];
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_processor_pin_saida.sv
// Table-driven bench for processor_pin_saida: per-cycle vectors feed a
// scoreboard queue that is drained after each rising edge.
module tb_processor_pin_saida;

    logic        clk;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [3:0]  out_port;

    int checks = 0;
    int errors = 0;

    processor_pin_saida #(
        .DATA_WIDTH (4),
        .RESET_VALUE(4'h0),
        .CNT_WIDTH  (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .out_port  (out_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        cs;
        logic        wn;
        logic [2:0]  a;
        logic [31:0] wd;
        logic [3:0]  eo;
        logic [31:0] er;
    } vec_t;

    typedef struct {
        int          idx;
        logic [3:0]  eo;
        logic [31:0] er;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    task automatic add(input logic rst, input logic cs, input logic wn,
                       input logic [2:0] a, input logic [31:0] wd,
                       input logic [3:0] eo, input logic [31:0] er);
        vec_t v;
        v.rst = rst; v.cs = cs; v.wn = wn; v.a = a; v.wd = wd; v.eo = eo; v.er = er;
        vecs.push_back(v);
    endtask

    task automatic wr_v(input logic [2:0] a, input logic [31:0] wd,
                        input logic [3:0] eo, input logic [31:0] er);
        add(1'b0, 1'b1, 1'b0, a, wd, eo, er);
    endtask

    task automatic idle_v(input logic [2:0] a, input logic [3:0] eo, input logic [31:0] er);
        add(1'b0, 1'b0, 1'b1, a, 32'h0, eo, er);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    // Scoreboard consumer: expectations pushed at the driving negedge are
    // compared just after the following rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check($sformatf("vec%0d out_port", e.idx), {28'h0, out_port}, {28'h0, e.eo});
                check($sformatf("vec%0d readdata", e.idx), readdata, e.er);
            end
        end
    end

    initial begin
        int n;
        exp_t e;

        reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = 3'd0; writedata = '0;

        // Reset wins over a concurrent write
        add(1'b1, 1'b1, 1'b0, 3'd0, 32'hF, 4'h0, 32'h0);
        idle_v(3'd3, 4'h0, 32'h0);
        // Basic data / set / clear, strobe gating, ignored address 1
        wr_v(3'd0, 32'hA, 4'hA, 32'h0);
        idle_v(3'd0, 4'hA, 32'hA);
        wr_v(3'd4, 32'h1, 4'hB, 32'h0);
        wr_v(3'd5, 32'h8, 4'h3, 32'h0);
        wr_v(3'd1, 32'hF, 4'h3, 32'h3);
        add(1'b0, 1'b0, 1'b0, 3'd0, 32'hF, 4'h3, 32'h3);
        add(1'b0, 1'b1, 1'b1, 3'd0, 32'hF, 4'h3, 32'h3);
        // Pulse of 5 with mask 5, overrun mid-pulse then cleared
        wr_v(3'd2, 32'h5, 4'h3, 32'h0);
        idle_v(3'd2, 4'h3, 32'h5);
        wr_v(3'd3, 32'h5, 4'h6, 32'h0);
        idle_v(3'd3, 4'h6, 32'h1);
        idle_v(3'd3, 4'h6, 32'h1);
        wr_v(3'd3, 32'h2, 4'h6, 32'h1);
        wr_v(3'd3, 32'h8000_0000, 4'h6, 32'h3);
        idle_v(3'd3, 4'h3, 32'h1);
        idle_v(3'd3, 4'h3, 32'h0);
        // pulse_len 0 and mask 0 are no-ops
        wr_v(3'd2, 32'h0, 4'h3, 32'h5);
        wr_v(3'd3, 32'hF, 4'h3, 32'h0);
        idle_v(3'd3, 4'h3, 32'h0);
        wr_v(3'd2, 32'h4, 4'h3, 32'h0);
        wr_v(3'd3, 32'h0, 4'h3, 32'h0);
        idle_v(3'd3, 4'h3, 32'h0);
        // Data write during a 4-cycle pulse on bit 0
        wr_v(3'd3, 32'h1, 4'h2, 32'h0);
        wr_v(3'd0, 32'hC, 4'hD, 32'h3);
        idle_v(3'd1, 4'hD, 32'hD);
        idle_v(3'd1, 4'hD, 32'hD);
        idle_v(3'd1, 4'hC, 32'hD);
        idle_v(3'd1, 4'hC, 32'hC);
        // Reset mid-pulse
        wr_v(3'd3, 32'h6, 4'hA, 32'h0);
        idle_v(3'd3, 4'hA, 32'h1);
        add(1'b1, 1'b0, 1'b1, 3'd3, 32'h0, 4'h0, 32'h0);
        idle_v(3'd3, 4'h0, 32'h0);
        idle_v(3'd0, 4'h0, 32'h0);
        idle_v(3'd2, 4'h0, 32'h0);
        // Upper bits are dropped on write and read back as zero
        wr_v(3'd2, 32'hFFFF_FFFF, 4'h0, 32'h0);
        idle_v(3'd2, 4'h0, 32'h0000_FFFF);
        wr_v(3'd0, 32'hFFFF_FFF5, 4'h5, 32'h0);
        idle_v(3'd0, 4'h5, 32'h5);
        // Two-cycle pulse, sticky overrun, cleared from IDLE
        wr_v(3'd2, 32'h2, 4'h5, 32'hFFFF);
        wr_v(3'd3, 32'h1, 4'h4, 32'h0);
        wr_v(3'd3, 32'h2, 4'h4, 32'h1);
        idle_v(3'd3, 4'h5, 32'h3);
        idle_v(3'd3, 4'h5, 32'h2);
        wr_v(3'd3, 32'h8000_0000, 4'h5, 32'h2);
        idle_v(3'd3, 4'h5, 32'h0);
        // Minimum pulse length of one cycle
        wr_v(3'd2, 32'h1, 4'h5, 32'h2);
        wr_v(3'd3, 32'h8, 4'hD, 32'h0);
        idle_v(3'd3, 4'h5, 32'h1);
        idle_v(3'd3, 4'h5, 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset      = vecs[i].rst;
            chipselect = vecs[i].cs;
            write_n    = vecs[i].wn;
            address    = vecs[i].a;
            writedata  = vecs[i].wd;
            e.idx = i; e.eo = vecs[i].eo; e.er = vecs[i].er;
            sb.push_back(e);
        end
        @(negedge clk);
        reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
        repeat (2) @(negedge clk);
        check("scoreboard drained", sb.size(), 0);

        // Long pulse: 40 cycles of inversion on all pins, bounded wait
        bus_write(3'd0, 32'h3);
        bus_write(3'd2, 32'd40);
        address = 3'd3;
        bus_write(3'd3, 32'hF);
        n = 0;
        while (out_port == 4'hC && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("long pulse length", n, 40);
        check("long pulse restore", {28'h0, out_port}, 32'h3);
        @(negedge clk);
        check("long pulse busy clear", readdata, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
